// File: rtl/mask_row_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : mask_row_streamer
//  Description : Pops 256-bit mask words from a first-word-fall-through cache
//                FIFO and serialises each one into sixteen 16-bit beats on the
//                sensor mSTREAM pins. Beats advance only while the exposure
//                controller holds stream_en_i high. The block tracks the row
//                and pattern position within a frame and flags FIFO underflow.
//
//  Parameters  : ROW_BEATS    16-bit beats per sensor row (320 cols / 16)
//
//  Ports       : clk          system clock, rising edge
//                reset        synchronous, active-high reset
//                num_pat      patterns per frame (0 -> 1), sampled at frame start
//                num_row      rows per pattern  (0 -> 1), sampled at frame start
//                stream_en_i  exposure EN_STREAM level; beats advance while high
//                glob_res     PIXGLOB_RES from the exposure controller
//                cache_dout   FIFO head word (FWFT)
//                cache_valid  cache_dout is valid
//                cache_empty  FIFO empty (cache_valid already carries this)
//                cache_rd_en  pop strobe, combinational from state
//                mstream      registered mask beat
//                beat_valid   registered, mstream carries a real beat
//                row_cnt      current row within the pattern
//                pat_cnt      current pattern within the frame
//                frame_done   one-cycle pulse after the last beat of a frame
//                underflow    sticky, a beat was needed and no word was there
//
//  Build macro : GLOB_RES_FORCE_EN
//                defined   -> glob_res=1 freezes the stream and forces
//                             mstream to 16'hFFFF with beat_valid low
//                undefined -> glob_res is ignored
//
//  Revision    : 1.0  initial release
// ============================================================================
module mask_row_streamer #(
    parameter int ROW_BEATS = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   num_pat,
    input  logic [9:0]   num_row,
    input  logic         stream_en_i,
    input  logic         glob_res,
    input  logic [255:0] cache_dout,
    input  logic         cache_valid,
    input  logic         cache_empty,
    output logic         cache_rd_en,
    output logic [15:0]  mstream,
    output logic         beat_valid,
    output logic [9:0]   row_cnt,
    output logic [7:0]   pat_cnt,
    output logic         frame_done,
    output logic         underflow
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_BIR_W = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
    localparam logic [c_BIR_W-1:0] c_BIR_LAST = c_BIR_W'(ROW_BEATS - 1);
    localparam logic [c_BIR_W-1:0] c_BIR_ONE  = c_BIR_W'(1);

    // Number of 16-bit beats carried by one 256-bit cache word
    localparam logic [4:0] c_WORD_BEATS = 5'd16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [255:0]       r_sr;           // word being serialised, LSB beat next
    logic [4:0]         r_word_beats;   // beats still unread in r_sr
    logic [c_BIR_W-1:0] r_bir;          // beat position within the row
    logic [9:0]         r_row;
    logic [7:0]         r_pat;
    logic [9:0]         r_nr;           // rows per pattern latched at frame start
    logic [7:0]         r_np;           // patterns per frame latched at frame start
    logic [15:0]        r_mstream;
    logic               r_beat_valid;
    logic               r_frame_done;
    logic               r_underflow;

    // ------------------------------------------------------------------------
    // Stream qualifier. With the forcing option a global pixel reset freezes
    // the stream exactly like a low stream enable.
    // ------------------------------------------------------------------------
    logic w_run;
    logic w_force_ones;
    logic w_unused_ok;

`ifdef GLOB_RES_FORCE_EN
    assign w_run        = stream_en_i & ~glob_res;
    assign w_force_ones = glob_res;
    assign w_unused_ok  = cache_empty;
`else
    assign w_run        = stream_en_i;
    assign w_force_ones = 1'b0;
    assign w_unused_ok  = ^{cache_empty, glob_res};
`endif

    // ------------------------------------------------------------------------
    // Position decode. Compares are against the latched frame geometry so a
    // mid-frame change of num_row / num_pat has no effect until the next
    // frame.
    // ------------------------------------------------------------------------
    logic w_row_end;
    logic w_pat_end;
    logic w_frame_end;
    logic w_word_end;
    logic w_pop;

    assign w_row_end   = (r_bir == c_BIR_LAST);
    assign w_pat_end   = w_row_end & (r_row == (r_nr - 10'd1));
    assign w_frame_end = w_pat_end & (r_pat == (r_np - 8'd1));
    assign w_word_end  = (r_word_beats == 5'd1);

    // FWFT: the head word is consumed in the same cycle it is seen valid.
    assign w_pop       = (r_state == S_FETCH) & cache_valid & w_run;
    assign cache_rd_en = w_pop;

    // ------------------------------------------------------------------------
    // Control and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sr         <= '0;
            r_word_beats <= '0;
            r_bir        <= '0;
            r_row        <= '0;
            r_pat        <= '0;
            r_nr         <= 10'd1;
            r_np         <= 8'd1;
            r_mstream    <= '0;
            r_beat_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            // Output beat defaults: idle cycles drive zero, or all-ones while
            // a forced global reset is in progress.
            r_mstream    <= w_force_ones ? 16'hFFFF : 16'h0000;
            r_beat_valid <= 1'b0;
            r_frame_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_run) begin
                        r_np    <= (num_pat == 8'd0)  ? 8'd1  : num_pat;
                        r_nr    <= (num_row == 10'd0) ? 10'd1 : num_row;
                        r_bir   <= '0;
                        r_row   <= '0;
                        r_pat   <= '0;
                        r_state <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (w_pop) begin
                        r_sr         <= cache_dout;
                        r_word_beats <= c_WORD_BEATS;
                        r_state      <= S_SHIFT;
                    end else if (w_run) begin
                        // Wanted a word and the FIFO had none; a paused
                        // stream never flags.
                        r_underflow <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (w_run) begin
                        r_mstream    <= r_sr[15:0];
                        r_beat_valid <= 1'b1;
                        r_sr         <= {16'h0000, r_sr[255:16]};
                        r_word_beats <= r_word_beats - 5'd1;

                        if (w_frame_end) begin
                            // Final beat of the frame: counters stay on the
                            // last position, any unread beats are dropped.
                            r_sr         <= '0;
                            r_word_beats <= '0;
                            r_state      <= S_DONE;
                        end else begin
                            // Beats pack continuously across row and
                            // pattern boundaries.
                            if (w_row_end) begin
                                r_bir <= '0;
                                if (w_pat_end) begin
                                    r_row <= '0;
                                    r_pat <= r_pat + 8'd1;
                                end else begin
                                    r_row <= r_row + 10'd1;
                                end
                            end else begin
                                r_bir <= r_bir + c_BIR_ONE;
                            end

                            if (w_word_end) begin
                                r_state <= S_FETCH;
                            end
                        end
                    end
                end

                S_DONE: begin
                    r_frame_done <= 1'b1;
                    r_state      <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign mstream    = r_mstream;
    assign beat_valid = r_beat_valid;
    assign row_cnt    = r_row;
    assign pat_cnt    = r_pat;
    assign frame_done = r_frame_done;
    assign underflow  = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_mask_row_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mask_row_streamer
//  Description : Directed self-checking bench for mask_row_streamer. A queue
//                models the FWFT cache FIFO; a negedge monitor records every
//                beat with its cycle stamp and position counters.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mask_row_streamer;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   num_pat;
    logic [9:0]   num_row;
    logic         stream_en;
    logic         glob_res;
    logic [255:0] cache_dout = '0;
    logic         cache_valid = 1'b0;
    logic         cache_empty = 1'b1;
    logic         cache_rd_en;
    logic [15:0]  mstream;
    logic         beat_valid;
    logic [9:0]   row_cnt;
    logic [7:0]   pat_cnt;
    logic         frame_done;
    logic         underflow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mask_row_streamer #(.ROW_BEATS(20)) dut (
        .clk         (clk),
        .reset       (reset),
        .num_pat     (num_pat),
        .num_row     (num_row),
        .stream_en_i (stream_en),
        .glob_res    (glob_res),
        .cache_dout  (cache_dout),
        .cache_valid (cache_valid),
        .cache_empty (cache_empty),
        .cache_rd_en (cache_rd_en),
        .mstream     (mstream),
        .beat_valid  (beat_valid),
        .row_cnt     (row_cnt),
        .pat_cnt     (pat_cnt),
        .frame_done  (frame_done),
        .underflow   (underflow)
    );

    // ------------------------------------------------------------------------
    // FWFT FIFO model
    // ------------------------------------------------------------------------
    logic [255:0] fifo_q[$];
    int n_pops = 0;

    always @(posedge clk) begin
        if (reset) begin
            n_pops = 0;
        end else if (cache_rd_en && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            n_pops = n_pops + 1;
        end
    end

    always @(negedge clk) begin
        cache_valid = (fifo_q.size() > 0);
        cache_empty = !cache_valid;
        cache_dout  = cache_valid ? fifo_q[0] : '0;
    end

    // Word w carries beats {w, 4'hA, k} for k = 0..15, slice k at bits 16k.
    function automatic logic [255:0] gen_word(input int w);
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) begin
            v[16*k +: 16] = {w[7:0], 4'hA, k[3:0]};
        end
        return v;
    endfunction

    // Expected value of the n-th beat of a frame, words numbered from 0.
    function automatic logic [15:0] exp_beat(input int n);
        return {n[11:4], 4'hA, n[3:0]};
    endfunction

    // ------------------------------------------------------------------------
    // Beat monitor
    // ------------------------------------------------------------------------
    int n_beats, n_done, done_cyc, n_idle_bad, n_data_bad;
    int         beat_cyc [0:127];
    logic [9:0] row_at   [0:127];
    logic [7:0] pat_at   [0:127];

    always @(negedge clk) begin
        if (reset) begin
            n_beats    = 0;
            n_done     = 0;
            done_cyc   = 0;
            n_idle_bad = 0;
            n_data_bad = 0;
        end else begin
            if (beat_valid) begin
                if (n_beats < 128) begin
                    beat_cyc[n_beats] = cyc;
                    row_at[n_beats]   = row_cnt;
                    pat_at[n_beats]   = pat_cnt;
                end
                if (mstream !== exp_beat(n_beats)) n_data_bad = n_data_bad + 1;
                n_beats = n_beats + 1;
            end else if (mstream !== 16'h0000) begin
                n_idle_bad = n_idle_bad + 1;
            end
            if (frame_done) begin
                n_done   = n_done + 1;
                done_cyc = cyc;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        stream_en = 1'b0;
        glob_res  = 1'b0;
        fifo_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push_words(input int first, input int count);
        for (int i = 0; i < count; i++) fifo_q.push_back(gen_word(first + i));
    endtask

    // Returns in the cycle where the target-th beat is visible on mstream.
    task automatic wait_beats(input int target, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (n_beats + int'(beat_valid) >= target) return;
        end
        check("wait_beats_timeout", 32'(n_beats), 32'(target));
    endtask

    // Returns in the cycle frame_done is high and drops the stream enable.
    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (frame_done) begin
                stream_en = 1'b0;
                return;
            end
        end
        stream_en = 1'b0;
        check("frame_done_timeout", 32'd0, 32'd1);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    int t_start;
    logic [9:0] row_hold;

    initial begin
        num_pat = 8'd1;
        num_row = 10'd4;
        do_reset();

        // Reset values
        check("rst_mstream",    32'(mstream),     32'h0);
        check("rst_beat_valid", 32'(beat_valid),  32'h0);
        check("rst_rd_en",      32'(cache_rd_en), 32'h0);
        check("rst_row",        32'(row_cnt),     32'h0);
        check("rst_pat",        32'(pat_cnt),     32'h0);
        check("rst_done",       32'(frame_done),  32'h0);
        check("rst_underflow",  32'(underflow),   32'h0);

        // Basic 1x4 frame: 80 beats from 5 words, bubble per word
        push_words(0, 5);
        stream_en = 1'b1;
        t_start   = cyc;
        wait_done(200);
        repeat (3) @(posedge clk);
        #1;
        check("t1_beats",      32'(n_beats),                    32'd80);
        check("t1_data_errs",  32'(n_data_bad),                 32'd0);
        check("t1_idle_zero",  32'(n_idle_bad),                 32'd0);
        check("t1_first_beat", 32'(exp_beat(0)),                32'h00A0);
        check("t1_latency",    32'(beat_cyc[0] - t_start),      32'd3);
        check("t1_word_span",  32'(beat_cyc[15] - beat_cyc[0]), 32'd15);
        check("t1_bubble",     32'(beat_cyc[16] - beat_cyc[15]), 32'd2);
        check("t1_frame_span", 32'(beat_cyc[79] - beat_cyc[0]), 32'd83);
        check("t1_done_lag",   32'(done_cyc - beat_cyc[79]),    32'd1);
        check("t1_done_cnt",   32'(n_done),                     32'd1);
        check("t1_pops",       32'(n_pops),                     32'd5);
        check("t1_underflow",  32'(underflow),                  32'd0);
        check("t1_row_end",    32'(row_cnt),                    32'd3);
        check("t1_row_wrap",   32'(row_at[19]),                 32'd1);

        // Underflow: one word for a 1x2 frame, stall, then refill
        do_reset();
        num_pat = 8'd1;
        num_row = 10'd2;
        push_words(0, 1);
        stream_en = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("t2_stall_beats", 32'(n_beats),     32'd16);
        check("t2_underflow",   32'(underflow),   32'd1);
        check("t2_stall_rd_en", 32'(cache_rd_en), 32'd0);
        check("t2_stall_row",   32'(row_cnt),     32'd0);
        push_words(1, 2);
        wait_done(100);
        repeat (20) @(posedge clk);
        #1;
        check("t2_beats",     32'(n_beats),    32'd40);
        check("t2_data_errs", 32'(n_data_bad), 32'd0);
        check("t2_row_b18",   32'(row_at[18]), 32'd0);
        check("t2_row_b19",   32'(row_at[19]), 32'd1);
        check("t2_sticky",    32'(underflow),  32'd1);
        check("t2_pops",      32'(n_pops),     32'd3);

        // Pause for 7 cycles after the 9th beat
        do_reset();
        num_pat = 8'd1;
        num_row = 10'd4;
        push_words(0, 5);
        stream_en = 1'b1;
        wait_beats(9, 50);
        stream_en = 1'b0;
        row_hold  = row_cnt;
        repeat (7) @(posedge clk);
        #1;
        check("t3_pause_beats", 32'(n_beats),   32'd9);
        check("t3_pause_row",   32'(row_cnt),   32'(row_hold));
        check("t3_pause_uf",    32'(underflow), 32'd0);
        stream_en = 1'b1;
        wait_done(200);
        repeat (3) @(posedge clk);
        #1;
        check("t3_gap",        32'(beat_cyc[9] - beat_cyc[8]), 32'd8);
        check("t3_beats",      32'(n_beats),                   32'd80);
        check("t3_data_errs",  32'(n_data_bad),                32'd0);
        check("t3_underflow",  32'(underflow),                 32'd0);

        // Zero configuration behaves as 1x1; leftover beats discarded
        do_reset();
        num_pat = 8'd0;
        num_row = 10'd0;
        push_words(0, 2);
        stream_en = 1'b1;
        wait_done(100);
        repeat (20) @(posedge clk);
        #1;
        check("t4_beats",     32'(n_beats),       32'd20);
        check("t4_data_errs", 32'(n_data_bad),    32'd0);
        check("t4_done_cnt",  32'(n_done),        32'd1);
        check("t4_pops",      32'(n_pops),        32'd2);
        check("t4_fifo_left", 32'(fifo_q.size()), 32'd0);
        check("t4_row",       32'(row_cnt),       32'd0);

        // 2 patterns x 1 row; live inputs change mid-frame and are ignored
        do_reset();
        num_pat = 8'd2;
        num_row = 10'd1;
        push_words(0, 3);
        stream_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        num_pat = 8'd5;
        num_row = 10'd7;
        wait_done(100);
        repeat (20) @(posedge clk);
        #1;
        check("t6_beats",     32'(n_beats),    32'd40);
        check("t6_data_errs", 32'(n_data_bad), 32'd0);
        check("t6_pat_b18",   32'(pat_at[18]), 32'd0);
        check("t6_pat_b19",   32'(pat_at[19]), 32'd1);
        check("t6_row_b19",   32'(row_at[19]), 32'd0);
        check("t6_pat_end",   32'(pat_cnt),    32'd1);
        check("t6_pops",      32'(n_pops),     32'd3);

        // Reset in the middle of a frame
        do_reset();
        num_pat = 8'd1;
        num_row = 10'd4;
        push_words(0, 5);
        stream_en = 1'b1;
        wait_beats(30, 60);
        reset     = 1'b1;
        stream_en = 1'b0;
        @(posedge clk);
        #1;
        check("t5_mstream",   32'(mstream),       32'h0);
        check("t5_valid",     32'(beat_valid),    32'h0);
        check("t5_rd_en",     32'(cache_rd_en),   32'h0);
        check("t5_row",       32'(row_cnt),       32'h0);
        check("t5_pat",       32'(pat_cnt),       32'h0);
        check("t5_done",      32'(frame_done),    32'h0);
        check("t5_fifo_kept", 32'(fifo_q.size()), 32'd3);
        reset = 1'b0;

`ifdef GLOB_RES_FORCE_EN
        // Forced global reset freezes the stream for 3 cycles
        do_reset();
        num_pat = 8'd1;
        num_row = 10'd1;
        push_words(0, 2);
        stream_en = 1'b1;
        wait_beats(5, 40);
        glob_res = 1'b1;
        row_hold = 10'(n_beats + int'(beat_valid));
        @(posedge clk);
        #1;
        check("t7_force_ones", 32'(mstream),    32'hFFFF);
        check("t7_force_valid", 32'(beat_valid), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        glob_res = 1'b0;
        check("t7_frozen", 32'(n_beats + int'(beat_valid)), 32'(row_hold));
        wait_done(100);
        repeat (3) @(posedge clk);
        #1;
        check("t7_beats", 32'(n_beats), 32'd20);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
